// File: rtl/iterate_pkg.sv
// Shared types and default widths for the iterate_stride range generator.
package iterate_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_COUNT_W = 16;

  // IDLE: no beat presented; RUN: a beat is presented on the iter_* port
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/iterate_slot.sv
// One-entry pending register for a range command (start, count, stride).
// Stride storage exists only when ITERATE_STRIDE_SIGNED_STRIDE_EN is defined.
module iterate_slot
  import iterate_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_start,
  input  logic [COUNT_W-1:0] in_count,
  input  logic [DATA_W-1:0]  in_stride,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_start,
  output logic [COUNT_W-1:0] out_count,
  output logic [DATA_W-1:0]  out_stride
);

  logic full_q;
  logic full_d;

  // Occupancy update: a pop empties, a push fills
  always_comb begin
    full_d = full_q;
    if (out_ready) full_d = 1'b0;
    if (in_valid && in_ready) full_d = 1'b1;
  end

  // Occupancy flag and registered ready; ready stays low while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      full_q   <= full_d;
      in_ready <= ~full_d;
    end
  end

  // Payload capture on push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_start <= '0;
      out_count <= '0;
    end else if (in_valid && in_ready) begin
      out_start <= in_start;
      out_count <= in_count;
    end
  end

`ifdef ITERATE_STRIDE_SIGNED_STRIDE_EN
  // Stride capture on push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_stride <= '0;
    end else if (in_valid && in_ready) begin
      out_stride <= in_stride;
    end
  end
`else
  logic unused_stride;
  assign unused_stride = ^in_stride;
  assign out_stride    = '0;
`endif

  assign out_valid = full_q;

endmodule

// File: rtl/iterate_stride.sv
// Range-to-beat generator: emits start + k*stride for k = 0..count-1 with
// first/last markers, one pending range queued behind the active one.
// Macro ITERATE_STRIDE_SIGNED_STRIDE_EN enables the programmable stride;
// without it the stride is fixed at 1 and range_stride is ignored.
module iterate_stride
  import iterate_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               range_valid,
  output logic               range_ready,
  input  logic [DATA_W-1:0]  range_start,
  input  logic [COUNT_W-1:0] range_count,
  input  logic [DATA_W-1:0]  range_stride,
  output logic               iter_valid,
  input  logic               iter_ready,
  output logic [DATA_W-1:0]  iter_data,
  output logic               iter_first,
  output logic               iter_last
);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0]  data_d;
  logic               first_d, last_d, valid_d;
  logic [DATA_W-1:0]  stride_eff;

  logic               slot_valid;
  logic [DATA_W-1:0]  slot_start;
  logic [COUNT_W-1:0] slot_count;
  logic [DATA_W-1:0]  slot_stride;

  logic beat_xfer, last_xfer, range_live, load_direct, load_slot, slot_push;

  assign beat_xfer  = iter_valid & iter_ready;
  assign last_xfer  = beat_xfer & iter_last;
  assign range_live = range_valid & range_ready & (range_count != '0);
  // A range accepted while the active one finishes (slot empty) starts directly
  assign load_direct = range_live & ((state_q == ST_IDLE) | last_xfer);
  assign slot_push   = range_live & (state_q == ST_RUN) & ~last_xfer;
  assign load_slot   = last_xfer & slot_valid;

  iterate_slot #(
    .DATA_W (DATA_W),
    .COUNT_W(COUNT_W)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (slot_push),
    .in_ready  (range_ready),
    .in_start  (range_start),
    .in_count  (range_count),
    .in_stride (range_stride),
    .out_valid (slot_valid),
    .out_ready (load_slot),
    .out_start (slot_start),
    .out_count (slot_count),
    .out_stride(slot_stride)
  );

`ifdef ITERATE_STRIDE_SIGNED_STRIDE_EN
  logic [DATA_W-1:0] stride_q, stride_d;
  assign stride_eff = stride_q;
`else
  logic unused_slot_stride;
  assign unused_slot_stride = ^slot_stride;
  assign stride_eff         = DATA_W'(1);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load_direct) state_d = ST_RUN;
      ST_RUN:  if (last_xfer && !load_slot && !load_direct) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next beat: load a new range, advance, or retire the last beat
  always_comb begin
    data_d  = iter_data;
    rem_d   = rem_q;
    first_d = iter_first;
    last_d  = iter_last;
    valid_d = (state_d == ST_RUN);
`ifdef ITERATE_STRIDE_SIGNED_STRIDE_EN
    stride_d = stride_q;
`endif
    if (load_direct) begin
      data_d  = range_start;
      rem_d   = range_count - COUNT_W'(1);
      first_d = 1'b1;
      last_d  = (range_count == COUNT_W'(1));
`ifdef ITERATE_STRIDE_SIGNED_STRIDE_EN
      stride_d = range_stride;
`endif
    end else if (load_slot) begin
      data_d  = slot_start;
      rem_d   = slot_count - COUNT_W'(1);
      first_d = 1'b1;
      last_d  = (slot_count == COUNT_W'(1));
`ifdef ITERATE_STRIDE_SIGNED_STRIDE_EN
      stride_d = slot_stride;
`endif
    end else if (last_xfer) begin
      first_d = 1'b0;
      last_d  = 1'b0;
    end else if (beat_xfer) begin
      data_d  = iter_data + stride_eff;
      rem_d   = rem_q - COUNT_W'(1);
      first_d = 1'b0;
      last_d  = (rem_q == COUNT_W'(1));
    end
  end

  // Registered beat outputs and remaining-beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_valid <= 1'b0;
      iter_data  <= '0;
      iter_first <= 1'b0;
      iter_last  <= 1'b0;
      rem_q      <= '0;
    end else begin
      iter_valid <= valid_d;
      iter_data  <= data_d;
      iter_first <= first_d;
      iter_last  <= last_d;
      rem_q      <= rem_d;
    end
  end

`ifdef ITERATE_STRIDE_SIGNED_STRIDE_EN
  // Active stride register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stride_q <= '0;
    else        stride_q <= stride_d;
  end
`endif

endmodule
